// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, counter types and window helpers
// for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] coord_t;

    localparam int unsigned DEF_H_DISP   = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_DISP   = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_DIV      = 4;
    localparam bit          DEF_SYNC_POL = 1'b0;

    localparam int unsigned H_TOTAL  = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL  = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned HS_START = DEF_H_DISP + DEF_H_FP;
    localparam int unsigned HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int unsigned VS_START = DEF_V_DISP + DEF_V_FP;
    localparam int unsigned VS_END   = VS_START + DEF_V_SYNC - 1;

    // Inclusive window test used for the sync pulse regions.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mod_m_tick.sv
// Free-running modulo-M counter emitting a one-clock tick on its last count;
// reusable wherever a fixed-rate enable is needed.
module mod_m_tick #(
    parameter int unsigned M = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    if (M < 2) begin : g_bad_m
        $error("mod_m_tick: M must be at least 2");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a divided
// pixel tick, registered syncs aligned with the counters, and a frame pulse.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISP   = DEF_H_DISP,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_DISP   = DEF_V_DISP,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned DIV      = DEF_DIV,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_tick
);

    localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST = CNT_W'(H_TOT - 1);
    localparam coord_t V_LAST = CNT_W'(V_TOT - 1);
    localparam coord_t H_VIS  = CNT_W'(H_DISP);
    localparam coord_t V_VIS  = CNT_W'(V_DISP);
    localparam coord_t HS_LO  = CNT_W'(H_DISP + H_FP);
    localparam coord_t HS_HI  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO  = CNT_W'(V_DISP + V_FP);
    localparam coord_t VS_HI  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("vga_sync_gen: raster totals exceed 10-bit counter range");
    end

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_tick_q, frame_tick_d;
    logic   tick;

    mod_m_tick #(
        .M(DIV)
    ) u_pix_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Counter advance; syncs decode the next-state counters so they stay aligned.
    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d      = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
        hsync_d = in_window(h_cnt_d, HS_LO, HS_HI) ? SYNC_POL : !SYNC_POL;
        vsync_d = in_window(v_cnt_d, VS_LO, VS_HI) ? SYNC_POL : !SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync_q      <= !SYNC_POL;
            vsync_q      <= !SYNC_POL;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign p_tick     = tick;
    assign pix_x      = h_cnt_q;
    assign pix_y      = v_cnt_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;
    assign video_on   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default 640x480 instance and a small
// DIV=2 / active-high instance, checked clock by clock against queued pixels.
module tb_vga_sync_gen;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit ft;
    } exp_t;

    localparam int S_HD = 16, S_HFP = 2, S_HSW = 4, S_HBP = 3;
    localparam int S_VD = 8,  S_VFP = 2, S_VSW = 2, S_VBP = 3;

    logic       clk;
    logic       rst_n;
    logic       hs0, vs0, von0, pt0, ft0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, von1, pt1, ft1;
    logic [9:0] x1, y1;

    vga_sync_gen u_dut0 (
        .clk       (clk),
        .reset     (rst_n),
        .hsync     (hs0),
        .vsync     (vs0),
        .video_on  (von0),
        .p_tick    (pt0),
        .pix_x     (x0),
        .pix_y     (y0),
        .frame_tick(ft0)
    );

    vga_sync_gen #(
        .H_DISP(S_HD), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_DISP(S_VD), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .DIV(2), .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (rst_n),
        .hsync     (hs1),
        .vsync     (vs1),
        .video_on  (von1),
        .p_tick    (pt1),
        .pix_x     (x1),
        .pix_y     (y1),
        .frame_tick(ft1)
    );

    // Observed instance selection.
    logic       sel;
    logic       m_hs, m_vs, m_von, m_pt, m_ft;
    logic [9:0] m_x, m_y;
    assign m_hs  = sel ? hs1  : hs0;
    assign m_vs  = sel ? vs1  : vs0;
    assign m_von = sel ? von1 : von0;
    assign m_pt  = sel ? pt1  : pt0;
    assign m_ft  = sel ? ft1  : ft0;
    assign m_x   = sel ? x1   : x0;
    assign m_y   = sel ? y1   : y0;

    // Timing of the observed instance, as the bench understands it.
    int hd, hfp, hsw, hbp, vd, vfp, vsw, vbp, div;
    bit pol;

    exp_t q[$];
    bit   mon_en;
    int   end_req, end_done;
    int   exp_hs_cnt, exp_vs_cnt, exp_von_cnt, exp_ft_cnt, exp_dec_cnt;
    int   total, bad;
    int   cip, k, hs_cnt, vs_cnt, von_cnt, ft_cnt, dec_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: reset values while in reset, queued pixels while running,
    // and end-of-phase statistics on request.
    always @(negedge clk) begin
        exp_t e;
        int   ht, fr;
        ht = hd + hfp + hsw + hbp;
        fr = ht * (vd + vfp + vsw + vbp);
        if (!rst_n) begin
            cip = 0; k = 0;
            hs_cnt = 0; vs_cnt = 0; von_cnt = 0; ft_cnt = 0; dec_cnt = 0;
            chk("rst_pix_x", 32'(m_x), 0);
            chk("rst_pix_y", 32'(m_y), 0);
            chk("rst_hsync", 32'(m_hs), 32'(!pol));
            chk("rst_vsync", 32'(m_vs), 32'(!pol));
            chk("rst_p_tick", 32'(m_pt), 0);
            chk("rst_frame_tick", 32'(m_ft), 0);
            chk("rst_video_on", 32'(m_von), 1);
        end else if (mon_en) begin
            chk("queue_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q[0];
                chk("p_tick", 32'(m_pt), 32'(cip == div - 1));
                chk("pix_x", 32'(m_x), 32'(e.x));
                chk("pix_y", 32'(m_y), 32'(e.y));
                chk("hsync", 32'(m_hs), 32'(e.hs));
                chk("vsync", 32'(m_vs), 32'(e.vs));
                chk("video_on", 32'(m_von), 32'(e.von));
                chk("frame_tick", 32'(m_ft), 32'(e.ft && cip == 0));
                if (m_ft === 1'b1) ft_cnt++;
                if (m_pt === 1'b1) begin
                    if (k < ht && m_hs === pol) hs_cnt++;
                    if (k < fr) begin
                        if (m_vs === pol) vs_cnt++;
                        if (m_von === 1'b1) von_cnt++;
                        if (32'(m_y) == vd + 1 && m_x == 10'd0) dec_cnt++;
                    end
                    void'(q.pop_front());
                    k++;
                    cip = 0;
                end else begin
                    cip++;
                end
            end
        end
        if (end_req != end_done) begin
            chk("queue_drained", 32'(q.size()), 0);
            chk("hsync_active_ticks", 32'(hs_cnt), 32'(exp_hs_cnt));
            chk("vsync_active_ticks", 32'(vs_cnt), 32'(exp_vs_cnt));
            chk("video_on_ticks", 32'(von_cnt), 32'(exp_von_cnt));
            chk("frame_tick_count", 32'(ft_cnt), 32'(exp_ft_cnt));
            chk("refresh_decode_count", 32'(dec_cnt), 32'(exp_dec_cnt));
            q.delete();
            end_done = end_req;
        end
    end

    // Expected pixel sequence from reset, derived arithmetically from tick index.
    task automatic push_ticks(input int n);
        int   ht, vt;
        exp_t e;
        ht = hd + hfp + hsw + hbp;
        vt = vd + vfp + vsw + vbp;
        for (int i = 0; i < n; i++) begin
            e.x   = i % ht;
            e.y   = (i / ht) % vt;
            e.hs  = (e.x >= hd + hfp && e.x < hd + hfp + hsw) ? pol : !pol;
            e.vs  = (e.y >= vd + vfp && e.y < vd + vfp + vsw) ? pol : !pol;
            e.von = (e.x < hd) && (e.y < vd);
            e.ft  = (i > 0) && (i % (ht * vt) == 0);
            q.push_back(e);
        end
    endtask

    task automatic run_phase(input int n, input int e_hs, input int e_vs,
                             input int e_von, input int e_ft, input int e_dec);
        int waited;
        exp_hs_cnt  = e_hs;
        exp_vs_cnt  = e_vs;
        exp_von_cnt = e_von;
        exp_ft_cnt  = e_ft;
        exp_dec_cnt = e_dec;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        push_ticks(n);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < n * div + 40) begin
            @(posedge clk);
            waited++;
        end
        mon_en = 1'b0;
        end_req++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; end_req = 0; end_done = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;

        // Default 640x480: two full lines plus the start of a third.
        sel = 1'b0; pol = 1'b0; div = 4;
        hd = 640; hfp = 16; hsw = 96; hbp = 48;
        vd = 480; vfp = 10; vsw = 2;  vbp = 33;
        run_phase(1610, 96, 0, 1290, 0, 0);

        // Small raster, DIV=2, active-high syncs: two frames and a few pixels.
        sel = 1'b1; pol = 1'b1; div = 2;
        hd = S_HD; hfp = S_HFP; hsw = S_HSW; hbp = S_HBP;
        vd = S_VD; vfp = S_VFP; vsw = S_VSW; vbp = S_VBP;
        run_phase(755, 4, 50, 128, 2, 1);

        // Partial frame; DUT keeps running mid-line until the next reset.
        run_phase(191, 4, 0, 128, 0, 0);

        // Reset asserted mid-frame and mid-tick, then one full frame again.
        run_phase(376, 4, 50, 128, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
